mux_rr_reg: RTL

- Parametrised N-channel, WIDTH-bit registered multiplexer; next generation of the team's 16-bit 2:1 combinational mux.
- Adds a per-channel valid/ready handshake, a registered output stage and two select modes: fixed (external sel) and round-robin.
- Sits between multiple producers and a single consumer datapath. Used wherever several sources share one bus.

---
 rtl/mux_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 39 +++
 rtl/mux_rr_reg.sv | 117 +++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the registered round-robin multiplexer:
// select-mode encodings and a constant-evaluable clog2 helper.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Width needed to index 'value' entries; never less than 1 bit.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int p = 1; p < value; p = p * 2) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter. Searches ptr+1, ptr+2, ...
// modulo N and grants the first requesting channel. Holds no state; the
// pointer register belongs to the parent.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int N     = 4,
    localparam int SEL_W = clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             en,
    output logic [SEL_W-1:0] grant_idx,
    output logic             grant_vld
);

    // Walk the channels in rotated order and keep the first requester.
    always_comb begin
        int idx;
        logic [SEL_W-1:0] cand;
        // NOTE: every output gets a default before the search loop, so no
        // path through this block leaves a value unassigned (no latch).
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = 0;
        cand      = '0;
        for (int off = 1; off <= N; off++) begin
            // NOTE: blocking assignments here because later loop
            // iterations must see the values written by earlier ones.
            idx  = (int'(ptr) + off) % N;
            cand = SEL_W'(idx);
            if (en && !grant_vld && req[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

endmodule

// File: rtl/mux_rr_reg.sv
// N-channel, WIDTH-bit registered multiplexer with per-channel valid/ready,
// a single-entry output register and fixed or round-robin selection.
// Optional build macro MUX_STATS_EN adds a 16-bit wrapping count of output
// handshakes on port xfer_count.
module mux_rr_reg
    import mux_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int N     = 4,
    localparam int SEL_W = clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     sel,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef MUX_STATS_EN
    output logic [15:0]          xfer_count,
`endif
    output logic [SEL_W-1:0]     out_ch
);

    logic [WIDTH-1:0] chan_data [N];
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] rr_idx;
    logic             rr_vld;
    logic             rr_en;
    logic [SEL_W-1:0] grant_idx;
    logic             grant_vld;
    logic             fix_vld;
    logic             load_en;
    logic             accept;

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign chan_data[i] = in_data[i*WIDTH +: WIDTH];
    end

    assign rr_en = (mode == MODE_RR);

    rr_arbiter #(.N(N)) u_arb (
        .req       (in_valid),
        .ptr       (rr_ptr),
        .en        (rr_en),
        .grant_idx (rr_idx),
        .grant_vld (rr_vld)
    );

    // Pick the granted channel: external select (range-checked) or arbiter.
    always_comb begin
        fix_vld   = 1'b0;
        grant_idx = '0;
        grant_vld = 1'b0;
        if (int'(sel) < N) begin
            fix_vld = in_valid[sel];
        end
        if (mode == MODE_RR) begin
            grant_idx = rr_idx;
            grant_vld = rr_vld;
        end else begin
            grant_idx = sel;
            grant_vld = fix_vld;
        end
    end

    // The output register can take a word when empty or draining this cycle;
    // nothing is accepted while reset is asserted.
    assign load_en = ~out_valid | out_ready;
    assign accept  = rst_n & grant_vld & load_en;

    // One-hot ready back to the granted producer only.
    always_comb begin
        in_ready = '0;
        if (accept) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    // Output register and round-robin pointer; load wins over plain drain.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all registered state so every
        // flop samples the values from before the clock edge.
        if (!rst_n) begin
            // NOTE: only control/output flops live here and all are reset;
            // a held word is discarded, there is no storage array to clear.
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= SEL_W'(N - 1);
        end else if (accept) begin
            out_data  <= chan_data[grant_idx];
            out_ch    <= grant_idx;
            out_valid <= 1'b1;
            if (mode == MODE_RR) begin
                rr_ptr <= grant_idx;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MUX_STATS_EN
    // Count consumer handshakes, wrapping naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xfer_count <= '0;
        end else if (out_valid && out_ready) begin
            xfer_count <= xfer_count + 16'd1;
        end
    end
`endif

endmodule
